// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_sub_pkg
//  Description : Shared definitions for the bit-serial subtractor controller.
//                Holds the FSM state encoding and state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

    // Three-state controller; the fourth encoding is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : serial_sub_pkg
`default_nettype wire

// File: rtl/fs_bit_cell.sv
`default_nettype none
// ============================================================================
//  Module      : fs_bit_cell
//  Description : Combinational 1-bit full subtractor, computes a - b - bin.
//  Ports       : a, b, bin  - minuend bit, subtrahend bit, borrow-in
//                d          - difference bit
//                bo         - borrow-out
//  Revision    : 1.0 - initial release
// ============================================================================
module fs_bit_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bin;
    // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
    assign bo = (~a & b) | (~(a ^ b) & bin);

endmodule : fs_bit_cell
`default_nettype wire

// File: rtl/serial_subtractor_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor_ctrl
//  Description : Bit-serial WIDTH-bit subtractor. Drives a single 1-bit full
//                subtractor cell over WIDTH cycles, LSB first, to compute
//                diff = a - b - bin with a start/busy/done handshake.
//  Ports       : clk, rst_n         - clock, async active-low reset
//                start              - request (honoured in IDLE or DONE)
//                a_in, b_in, bin_in - operands, sampled on the accepting edge
//                busy               - high while bits are being processed
//                done               - one-cycle pulse, result updated
//                diff_out, bout_out - result and final borrow, held to next done
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             bin_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff_out,
    output logic             bout_out
);

    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_load;
    logic             w_step;
    logic             w_last;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res_sh;
    logic             r_brw;
    logic [CNT_W-1:0] r_cnt;

    logic             w_d;
    logic             w_bo;
    logic [WIDTH-1:0] w_res_nxt;

    fs_bit_cell u_cell (
        .a   (r_a_sh[0]),
        .b   (r_b_sh[0]),
        .bin (r_brw),
        .d   (w_d),
        .bo  (w_bo)
    );

    // New difference bit enters at the MSB so the LSB-first stream lands in place.
    assign w_res_nxt = {w_d, r_res_sh[WIDTH-1:1]};

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // start is deliberately not looked at here: no queueing, no abort.
                w_step = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_brw    <= 1'b0;
            r_cnt    <= '0;
            diff_out <= '0;
            bout_out <= 1'b0;
        end else begin
            if (w_load) begin
                r_a_sh   <= a_in;
                r_b_sh   <= b_in;
                r_brw    <= bin_in;
                r_res_sh <= '0;
                r_cnt    <= '0;
            end else if (w_step) begin
                r_a_sh   <= r_a_sh >> 1;
                r_b_sh   <= r_b_sh >> 1;
                r_brw    <= w_bo;
                r_res_sh <= w_res_nxt;
                r_cnt    <= r_cnt + CNT_W'(1);
            end
            // Published outputs only move on the edge that enters DONE.
            if (w_last) begin
                diff_out <= w_res_nxt;
                bout_out <= w_bo;
            end
        end
    end

endmodule : serial_subtractor_ctrl
`default_nettype wire

// File: tb/tb_serial_subtractor_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_subtractor_ctrl
//  Description : Directed self-checking bench for serial_subtractor_ctrl at
//                WIDTH=4. Expected values come from hand-computed constants
//                and a 5-bit integer subtraction model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor_ctrl;

    localparam int WIDTH = 4;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b1;
    logic             start  = 1'b0;
    logic [WIDTH-1:0] a_in   = '0;
    logic [WIDTH-1:0] b_in   = '0;
    logic             bin_in = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff_out;
    logic             bout_out;

    int n_tests = 0;
    int n_fail  = 0;

    serial_subtractor_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a_in     (a_in),
        .b_in     (b_in),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .diff_out (diff_out),
        .bout_out (bout_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge while the DUT is in IDLE or DONE; returns #1 after
    // the accepting edge with start dropped.
    task automatic launch(input logic [3:0] a, input logic [3:0] b, input logic bi);
        a_in   = a;
        b_in   = b;
        bin_in = bi;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    // Counts edges until done is seen (bounded), and how many samples had busy.
    task automatic wait_done(output int cyc, output int bsy);
        cyc = 0;
        bsy = busy ? 1 : 0;
        while (!done && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (busy) bsy++;
        end
        if (!done) chk("done_timeout", {31'd0, done}, 32'd1);
    endtask

    function automatic logic [4:0] model(input logic [3:0] a, input logic [3:0] b, input logic bi);
        return {1'b0, a} - {1'b0, b} - {4'd0, bi};
    endfunction

    initial begin
        int cyc, bsy, ndone;
        logic [4:0] exp5;

        // ---------------------------------------------------------- reset
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_diff", {28'd0, diff_out}, 32'd0);
        chk("rst_bout", {31'd0, bout_out}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ------------------------------------------------- 9 - 3 - 0 = 6
        launch(4'd9, 4'd3, 1'b0);
        wait_done(cyc, bsy);
        chk("t1_latency", cyc, 32'd4);
        chk("t1_busy_cycles", bsy, 32'd4);
        chk("t1_diff", {28'd0, diff_out}, 32'h6);
        chk("t1_bout", {31'd0, bout_out}, 32'd0);
        chk("t1_no_busy_with_done", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        chk("t1_done_one_cycle", {31'd0, done}, 32'd0);
        chk("t1_diff_held", {28'd0, diff_out}, 32'h6);

        // ------------------------------------------------- 3 - 9 - 0 = A, borrow
        launch(4'd3, 4'd9, 1'b0);
        wait_done(cyc, bsy);
        chk("t2_diff", {28'd0, diff_out}, 32'hA);
        chk("t2_bout", {31'd0, bout_out}, 32'd1);

        // ------------------------------------------------- 0 - 0 - 1 = F, borrow
        launch(4'd0, 4'd0, 1'b1);
        wait_done(cyc, bsy);
        chk("t3_diff", {28'd0, diff_out}, 32'hF);
        chk("t3_bout", {31'd0, bout_out}, 32'd1);

        // ------------------------------------ start during RUN is ignored
        launch(4'd9, 4'd3, 1'b0);
        @(posedge clk); #1;
        a_in  = 4'd1;
        b_in  = 4'd7;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(cyc, bsy);
        chk("t4_latency", cyc, 32'd2);
        chk("t4_diff", {28'd0, diff_out}, 32'h6);
        chk("t4_bout", {31'd0, bout_out}, 32'd0);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("t4_single_done", ndone, 32'd0);

        // -------------------------------------- reset in the middle of RUN
        launch(4'd9, 4'd3, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_done", {31'd0, done}, 32'd0);
        chk("t5_diff", {28'd0, diff_out}, 32'd0);
        chk("t5_bout", {31'd0, bout_out}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("t5_no_done_after_release", ndone, 32'd0);
        chk("t5_diff_still_zero", {28'd0, diff_out}, 32'd0);

        // ----------------------------- start held high: back-to-back ops
        a_in = 4'd5; b_in = 4'd2; bin_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        wait_done(cyc, bsy);
        chk("t6a_diff", {28'd0, diff_out}, 32'h3);
        chk("t6a_bout", {31'd0, bout_out}, 32'd0);
        a_in = 4'd2; b_in = 4'd5; bin_in = 1'b1;
        @(posedge clk); #1;
        chk("t6b_no_done_consecutive", {31'd0, done}, 32'd0);
        wait_done(cyc, bsy);
        chk("t6b_period", cyc + 1, 32'd5);
        chk("t6b_diff", {28'd0, diff_out}, 32'hC);
        chk("t6b_bout", {31'd0, bout_out}, 32'd1);
        a_in = 4'd15; b_in = 4'd15; bin_in = 1'b0;
        @(posedge clk); #1;
        wait_done(cyc, bsy);
        chk("t6c_period", cyc + 1, 32'd5);
        chk("t6c_diff", {28'd0, diff_out}, 32'h0);
        chk("t6c_bout", {31'd0, bout_out}, 32'd0);
        start = 1'b0;
        @(posedge clk); #1;

        // ------------------------------------- exhaustive against a model
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int bi = 0; bi < 2; bi++) begin
                    launch(4'(a), 4'(b), 1'(bi));
                    wait_done(cyc, bsy);
                    exp5 = model(4'(a), 4'(b), 1'(bi));
                    chk($sformatf("exh a=%0d b=%0d bin=%0d", a, b, bi),
                        {27'd0, bout_out, diff_out}, {27'd0, exp5});
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_serial_subtractor_ctrl
`default_nettype wire
